pwm_multicanal: RTL and testbench

Parametrised N-channel PWM generator with per-channel soft fade for the lamp dimming path. It replaces per-channel PLL plus PWM instances with a single shared period counter and prescaler on one clock. Each channel holds a programmable target duty and ramps its active duty toward that target by a fixed step once per PWM period. All duty changes take effect only at period boundaries, so outputs are glitch-free.

---
 rtl/pwm_multicanal.sv | 105 ++++++++++
 tb/tb_pwm_multicanal.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multicanal.sv
// N-channel PWM with a shared prescaler/period counter and per-channel soft fade.
// Channel duty moves toward its target by STEP once per period, only at the boundary.

module pwm_multicanal_ch #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_duty,
  input  logic             bnd,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm,
  output logic             busy
);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH-1:0] tgt, cur, gap, nxt;

  // The gap is compared against STEP before adding/subtracting, so the step
  // never overshoots the target and the sum never leaves WIDTH bits.
  always_comb begin
    gap = '0;
    nxt = cur;
    if (cur < tgt) begin
      gap = tgt - cur;
      nxt = (gap > STEP_N) ? cur + STEP_N : tgt;
    end else if (cur > tgt) begin
      gap = cur - tgt;
      nxt = (gap > STEP_N) ? cur - STEP_N : tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt  <= '0;
      cur  <= '0;
      pwm  <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (ld)  tgt <= ld_duty;
      if (bnd) cur <= nxt;
      pwm  <= (cnt < cur);
      busy <= (cur != tgt);
    end
  end
endmodule

module pwm_multicanal #(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int PRESC = 1,
  parameter int STEP  = 1,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [N-1:0]     pwm,
  output logic [N-1:0]     busy,
  output logic             tick
);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]    PC_MAX  = PW'(PRESC - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PW-1:0]    pc;
  logic [WIDTH-1:0] cnt;
  logic             se, bnd;
  logic [N-1:0]     ld;

  assign se  = (pc == PC_MAX);
  assign bnd = se && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      pc   <= se ? '0 : pc + 1'b1;
      tick <= bnd;
      if (se) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // Out-of-range channel indices match no lane, so such writes simply vanish.
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ld[i] = wr_en && (wr_ch == CW'(i));

    pwm_multicanal_ch #(.WIDTH(WIDTH), .STEP(STEP)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld[i]),
      .ld_duty (wr_duty),
      .bnd     (bnd),
      .cnt     (cnt),
      .pwm     (pwm[i]),
      .busy    (busy[i])
    );
  end
endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal: four parameter sets driven by shared stimulus,
// checked every cycle against a period-arithmetic model plus literal duty/tick pins.

module tb_pwm_multicanal;
  localparam int NK = 4;
  localparam int PR [NK] = '{1, 1, 1, 3};
  localparam int SP [NK] = '{15, 2, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [3:0] wr_duty = '0;
  logic [2:0] pwm_o  [NK];
  logic [2:0] busy_o [NK];
  logic       tick_o [NK];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    pwm_multicanal #(.N(3), .WIDTH(4), .PRESC(PR[k]), .STEP(SP[k])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_duty (wr_duty),
      .pwm     (pwm_o[k]),
      .busy    (busy_o[k]),
      .tick    (tick_o[k])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: t counts edges since the reset edge; position in the period follows by division.
  int m_t = 0;
  int m_tgt [NK][3];
  int m_cur [NK][3];
  logic [2:0] e_pwm  [NK];
  logic [2:0] e_busy [NK];
  logic       e_tick [NK];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      int p, pos;
      bit b;
      p   = PR[k];
      pos = (m_t / p) % 15;
      b   = (m_t % (15 * p)) == (15 * p - 1);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_tgt[k][i] = 0; m_cur[k][i] = 0;
          e_pwm[k][i] = 1'b0; e_busy[k][i] = 1'b0;
        end else begin
          e_pwm[k][i]  = (pos < m_cur[k][i]);
          e_busy[k][i] = (m_cur[k][i] != m_tgt[k][i]);
          if (b) begin
            if (m_cur[k][i] < m_tgt[k][i])
              m_cur[k][i] = (m_cur[k][i] + SP[k] < m_tgt[k][i]) ? m_cur[k][i] + SP[k] : m_tgt[k][i];
            else if (m_cur[k][i] > m_tgt[k][i])
              m_cur[k][i] = (m_cur[k][i] - SP[k] > m_tgt[k][i]) ? m_cur[k][i] - SP[k] : m_tgt[k][i];
          end
          if (wr_en && int'(wr_ch) == i) m_tgt[k][i] = int'(wr_duty);
        end
      end
      e_tick[k] = rst ? 1'b0 : b;
    end
    m_t = rst ? 0 : m_t + 1;
  endtask

  // One clock: model updates on the edge, all DUTs are compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NK; k++)
      check($sformatf("cycle_k%0d", k), int'({pwm_o[k], busy_o[k], tick_o[k]}),
            int'({e_pwm[k], e_busy[k], e_tick[k]}));
  endtask

  task automatic write(input int ch, input int duty);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 4'(duty);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int k);
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (tick_o[k]) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  task automatic duty(input int k, input int ch, output int hi);
    hi = 0;
    repeat (15 * PR[k]) begin
      cyc();
      hi += int'(pwm_o[k][ch]);
    end
  endtask

  initial begin
    int hi, n, t0, t3a, t3b;
    int fade_up [4] = '{2, 4, 6, 7};
    int fade_dn [4] = '{5, 3, 1, 0};

    cyc(); cyc();
    for (int k = 0; k < NK; k++)
      check($sformatf("reset_k%0d", k), int'({pwm_o[k], busy_o[k], tick_o[k]}), 0);
    rst = 1'b0;

    n = 0;
    do begin cyc(); n++; end while (!tick_o[0] && n < 100);
    check("first_tick_latency", n, 15);

    // instant write, STEP=15
    write(0, 5);
    wait_tick(0);
    duty(0, 0, hi); check("k0_duty5", hi, 5);
    duty(0, 0, hi); check("k0_duty5_again", hi, 5);

    // fade on STEP=2
    write(1, 7);
    wait_tick(1);
    for (int j = 0; j < 4; j++) begin
      duty(1, 1, hi); check($sformatf("k1_fade_up%0d", j), hi, fade_up[j]);
    end
    write(1, 0);
    wait_tick(1);
    for (int j = 0; j < 4; j++) begin
      duty(1, 1, hi); check($sformatf("k1_fade_dn%0d", j), hi, fade_dn[j]);
    end

    // extremes on STEP=15
    write(2, 15);
    wait_tick(0);
    duty(0, 2, hi); check("k0_full_on", hi, 15);
    write(2, 0);
    wait_tick(0);
    duty(0, 2, hi); check("k0_full_off", hi, 0);

    // write coincident with the boundary, STEP=1
    write(0, 4);
    repeat (150) cyc();
    wait_tick(2);
    repeat (14) cyc();
    write(0, 10);
    duty(2, 0, hi); check("k2_coincident_hold", hi, 4);
    duty(2, 0, hi); check("k2_coincident_next", hi, 5);

    // invalid channel once everything has settled
    repeat (300) cyc();
    write(3, 9);
    repeat (3) cyc();
    for (int k = 0; k < NK; k++)
      check($sformatf("invalid_busy_k%0d", k), int'(busy_o[k]), 0);

    // reset in mid-fade, then tick spacing on both prescalers
    write(1, 15);
    wait_tick(1);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < NK; k++)
      check($sformatf("midreset_k%0d", k), int'({pwm_o[k], busy_o[k], tick_o[k]}), 0);
    t0 = 0; t3a = 0; t3b = 0;
    for (int c = 1; c <= 100; c++) begin
      cyc();
      if (tick_o[0] && t0 == 0) t0 = c;
      if (tick_o[3]) begin
        if (t3a == 0) t3a = c;
        else if (t3b == 0) t3b = c;
      end
    end
    check("post_reset_tick_k0", t0, 15);
    check("post_reset_tick_k3", t3a, 45);
    check("tick_spacing_k3", t3b - t3a, 45);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_duty = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    wr_en = 1'b0; rst = 1'b0;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
